// File: rtl/space_streams_splitter_ctrl.sv
// Per-symbol sequencer for the two-stream splitter: bursts one symbol from both demapper FIFOs,
// then holds until the splitter readout is finished. Optional watchdog via SPLIT_CTRL_TIMEOUT_EN.
module space_streams_splitter_ctrl #(
    parameter int MODULATION = 1,
    parameter int NSYM_W     = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [NSYM_W-1:0] N_SYM,
    input  logic              SS1_RDY,
    input  logic              SS2_RDY,
    input  logic              SPLIT_OUT_DV,
    output logic              SS_RD_EN,
    output logic              SPLIT_DV,
    output logic [NSYM_W-1:0] SYM_CNT,
    output logic              BUSY,
    output logic              DONE
`ifdef SPLIT_CTRL_TIMEOUT_EN
    ,
    output logic              ERR
`endif
);

    localparam logic [8:0]        BURST_LAST = 9'(52 * MODULATION - 1);
    localparam logic [NSYM_W-1:0] SYM_ONE    = NSYM_W'(1);

    typedef enum logic [1:0] {IDLE, WAIT_RDY, BURST, DRAIN} state_t;

    state_t            state;
    logic [8:0]        burst_cnt;
    logic [NSYM_W-1:0] n_sym_q;
    logic              seen_out;
    logic [NSYM_W-1:0] sym_next;

    assign sym_next = SYM_CNT + SYM_ONE;

`ifdef SPLIT_CTRL_TIMEOUT_EN
    // Firing when the count would step to 0xFFFF gives exactly 65535 waiting cycles.
    localparam logic [15:0] WD_LAST = 16'hFFFE;
    logic [15:0] wd_cnt;
`endif

    // NOTE: all state and outputs use non-blocking assignments so every branch reads
    // the pre-edge values; later assignments in the block override earlier defaults.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            burst_cnt <= '0;
            n_sym_q   <= '0;
            seen_out  <= 1'b0;
            SS_RD_EN  <= 1'b0;
            SPLIT_DV  <= 1'b0;
            SYM_CNT   <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
`ifdef SPLIT_CTRL_TIMEOUT_EN
            wd_cnt    <= '0;
            ERR       <= 1'b0;
`endif
        end else begin
            DONE     <= 1'b0;
            SPLIT_DV <= SS_RD_EN;   // FIFO read latency of one cycle
`ifdef SPLIT_CTRL_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
            if (ABORT) begin
                state     <= IDLE;
                burst_cnt <= '0;
                seen_out  <= 1'b0;
                SS_RD_EN  <= 1'b0;
                SPLIT_DV  <= 1'b0;
                BUSY      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (START) begin
`ifdef SPLIT_CTRL_TIMEOUT_EN
                            ERR <= 1'b0;
`endif
                            if (N_SYM != '0) begin
                                n_sym_q <= N_SYM;
                                SYM_CNT <= '0;
                                BUSY    <= 1'b1;
                                state   <= WAIT_RDY;
                            end else begin
                                DONE <= 1'b1;
                            end
                        end
                    end

                    WAIT_RDY: begin
                        if (SS1_RDY && SS2_RDY) begin
                            SS_RD_EN  <= 1'b1;
                            burst_cnt <= '0;
                            state     <= BURST;
                        end
`ifdef SPLIT_CTRL_TIMEOUT_EN
                        else if (wd_cnt == WD_LAST) begin
                            ERR   <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            wd_cnt <= wd_cnt + 16'd1;
                        end
`endif
                    end

                    BURST: begin
                        // RDY is not consulted here: a full symbol is already guaranteed.
                        if (burst_cnt == BURST_LAST) begin
                            SS_RD_EN  <= 1'b0;
                            burst_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            burst_cnt <= burst_cnt + 9'd1;
                        end
                    end

                    DRAIN: begin
                        if (seen_out && !SPLIT_OUT_DV) begin
                            seen_out <= 1'b0;
                            SYM_CNT  <= sym_next;
                            if (sym_next == n_sym_q) begin
                                DONE  <= 1'b1;
                                BUSY  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= WAIT_RDY;
                            end
                        end else begin
                            if (SPLIT_OUT_DV)
                                seen_out <= 1'b1;
`ifdef SPLIT_CTRL_TIMEOUT_EN
                            if (wd_cnt == WD_LAST) begin
                                seen_out <= 1'b0;
                                ERR      <= 1'b1;
                                BUSY     <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                wd_cnt <= wd_cnt + 16'd1;
                            end
`endif
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        SS_RD_EN <= 1'b0;
                        BUSY     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_space_streams_splitter_ctrl.sv
// Directed/randomized bench for space_streams_splitter_ctrl (MODULATION=4, 208-item bursts);
// timing is checked against expectations derived per symbol from the burst-length arithmetic.
module tb_space_streams_splitter_ctrl;

    localparam int MOD = 4;
    localparam int NW  = 10;
    localparam int L   = 52 * MOD;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [NW-1:0] n_sym;
    logic          ss1;
    logic          ss2;
    logic          out_dv;
    logic          ss_rd_en;
    logic          split_dv;
    logic [NW-1:0] sym_cnt;
    logic          busy;
    logic          done;
`ifdef SPLIT_CTRL_TIMEOUT_EN
    logic          err;
`endif

    int n_vec   = 0;
    int n_err   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    space_streams_splitter_ctrl #(
        .MODULATION (MOD),
        .NSYM_W     (NW)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .START        (start),
        .ABORT        (abort),
        .N_SYM        (n_sym),
        .SS1_RDY      (ss1),
        .SS2_RDY      (ss2),
        .SPLIT_OUT_DV (out_dv),
        .SS_RD_EN     (ss_rd_en),
        .SPLIT_DV     (split_dv),
        .SYM_CNT      (sym_cnt),
        .BUSY         (busy),
        .DONE         (done)
`ifdef SPLIT_CTRL_TIMEOUT_EN
        ,
        .ERR          (err)
`endif
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [NW-1:0] obs, input int exp);
        logic [NW-1:0] e;
        e = NW'(exp);
        n_vec++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
        end
    endtask

    // Advance one clock; outputs are then sampled and inputs driven 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt(input int n);
        start = 1'b1;
        n_sym = NW'(n);
        step();
        start = 1'b0;
        if (n != 0) exp_cnt = 0;
        chk("start_busy", busy, n != 0);
        chk("start_done", done, n == 0);
        chkc("start_symcnt", sym_cnt, exp_cnt);
    endtask

    // One symbol from WAIT_RDY through drain completion.
    task automatic run_symbol(input int n_total, input int gap, input bit toggle, input int start_at);
        logic [1:0] r;
        int g;
        int h;
        for (int i = 0; i < gap; i++) begin
            r = 2'($urandom_range(0, 2));
            {ss1, ss2} = r;
            step();
            chk("wait_rden", ss_rd_en, 1'b0);
            chk("wait_busy", busy, 1'b1);
        end
        ss1 = 1'b1;
        ss2 = 1'b1;
        step();
        for (int i = 0; i < L; i++) begin
            chk("burst_rden", ss_rd_en, 1'b1);
            chk("burst_dv", split_dv, i != 0);
            if (toggle) {ss1, ss2} = 2'($urandom);
            if (i == start_at) begin
                start = 1'b1;
                n_sym = NW'(1);
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        {ss1, ss2} = 2'($urandom);
        chk("burst_end_rden", ss_rd_en, 1'b0);
        chk("burst_tail_dv", split_dv, 1'b1);
        step();
        chk("drain_dv_low", split_dv, 1'b0);
        g = $urandom_range(0, 4);
        for (int i = 0; i < g; i++) begin
            step();
            chk("drain_rden", ss_rd_en, 1'b0);
            chkc("drain_symcnt", sym_cnt, exp_cnt);
        end
        out_dv = 1'b1;
        h = $urandom_range(1, 6);
        for (int i = 0; i < h; i++) begin
            step();
            chk("readout_done", done, 1'b0);
            chk("readout_busy", busy, 1'b1);
            chkc("readout_symcnt", sym_cnt, exp_cnt);
        end
        out_dv = 1'b0;
        step();
        exp_cnt++;
        chkc("sym_done_cnt", sym_cnt, exp_cnt);
        chk("sym_done_pulse", done, exp_cnt == n_total);
        chk("sym_done_busy", busy, exp_cnt != n_total);
        if (exp_cnt == n_total) begin
            step();
            chk("done_one_cycle", done, 1'b0);
            chk("idle_busy", busy, 1'b0);
        end
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        n_sym  = '0;
        ss1    = 1'b0;
        ss2    = 1'b0;
        out_dv = 1'b0;
        #12;
        chk("rst_rden", ss_rd_en, 1'b0);
        chk("rst_dv", split_dv, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chkc("rst_symcnt", sym_cnt, 0);
`ifdef SPLIT_CTRL_TIMEOUT_EN
        chk("rst_err", err, 1'b0);
`endif
        rst = 1'b0;
        step();

        // Single symbol with both RDY already high at START.
        ss1 = 1'b1;
        ss2 = 1'b1;
        start_pkt(1);
        run_symbol(1, 0, 1'b0, -1);

        // Three back-to-back symbols, RDY always high.
        start_pkt(3);
        for (int s = 0; s < 3; s++) run_symbol(3, 0, 1'b0, -1);

        // Long wait with only one RDY at a time.
        start_pkt(1);
        run_symbol(1, 50, 1'b0, -1);

        // Randomized packets with RDY jitter during bursts.
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 3);
            start_pkt(n);
            for (int s = 0; s < n; s++) run_symbol(n, $urandom_range(0, 8), 1'b1, -1);
        end

        // START during BURST is ignored.
        start_pkt(2);
        run_symbol(2, 0, 1'b0, 40);
        run_symbol(2, 2, 1'b0, -1);

        // ABORT mid-burst of the second symbol; SYM_CNT holds.
        start_pkt(3);
        run_symbol(3, 0, 1'b0, -1);
        ss1 = 1'b1;
        ss2 = 1'b1;
        step();
        for (int i = 0; i < 100; i++) begin
            chk("pre_abort_rden", ss_rd_en, 1'b1);
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_rden", ss_rd_en, 1'b0);
        chk("abort_dv", split_dv, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chkc("abort_symcnt", sym_cnt, 1);
        step();
        chk("post_abort_done", done, 1'b0);
        chk("post_abort_rden", ss_rd_en, 1'b0);
        start_pkt(1);
        run_symbol(1, 1, 1'b0, -1);

        // N_SYM=0 pulses DONE without going busy.
        start_pkt(0);
        step();
        chk("nsym0_done_low", done, 1'b0);
        chk("nsym0_busy", busy, 1'b0);

        // ABORT wins over a same-cycle START.
        start = 1'b1;
        abort = 1'b1;
        n_sym = NW'(0);
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_done", done, 1'b0);
        chk("abort_start_busy", busy, 1'b0);

        // Asynchronous reset mid-burst clears immediately.
        start_pkt(1);
        ss1 = 1'b1;
        ss2 = 1'b1;
        step();
        for (int i = 0; i < 30; i++) step();
        chk("pre_rst_rden", ss_rd_en, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rden", ss_rd_en, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chkc("async_rst_symcnt", sym_cnt, 0);
        chk("async_rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        step();
        chk("post_rst_busy", busy, 1'b0);

`ifdef SPLIT_CTRL_TIMEOUT_EN
        // Watchdog: RDY held low in WAIT_RDY for 65535 cycles.
        ss1 = 1'b0;
        ss2 = 1'b0;
        start_pkt(1);
        for (int i = 0; i < 65534; i++) step();
        chk("wd_err_before", err, 1'b0);
        chk("wd_busy_before", busy, 1'b1);
        step();
        chk("wd_err", err, 1'b1);
        chk("wd_busy", busy, 1'b0);
        chk("wd_done", done, 1'b0);
        step();
        chk("wd_err_latched", err, 1'b1);
        start_pkt(1);
        chk("wd_err_cleared", err, 1'b0);
        run_symbol(1, 0, 1'b0, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
